bcd_to_binary_seq: RTL and testbench

//  Sequential BCD-to-binary converter: the reverse of the binary-to-BCD path.

---
 rtl/bcd_to_binary_seq.sv | 94 +++++++++
 tb/tb_bcd_to_binary_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: multiply-accumulates one BCD digit per
// clock, most-significant digit first, and reports the result with a done pulse.
//
// state | meaning
// IDLE  | waiting for start; done may be high for one cycle after a completion
// CONV  | accumulating one digit per edge, DIGITS edges in total
module bcd_to_binary_seq #(
  parameter int DIGITS    = 4,
  parameter int BIN_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcdIn,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_WIDTH-1:0]  binOut
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } stateT;

  stateT                state;
  logic [BIN_WIDTH-1:0] acc;
  logic [BCD_W-1:0]     shReg;
  logic [CNT_W-1:0]     cnt;
  logic                 errPend;

  logic [3:0]           msNibble;
  logic [BIN_WIDTH-1:0] accNext;
  logic                 badIn;

  // acc*10 built from shifts; wraps silently at BIN_WIDTH bits.
  always_comb begin
    msNibble = shReg[BCD_W-1 -: 4];
    accNext  = (acc << 3) + (acc << 1) + BIN_WIDTH'(msNibble);
  end

  always_comb begin
    badIn = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcdIn[4*i +: 4] > 4'd9) badIn = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      acc     <= '0;
      shReg   <= '0;
      cnt     <= '0;
      errPend <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      binOut  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shReg   <= bcdIn;
            acc     <= '0;
            cnt     <= '0;
            errPend <= badIn;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          acc   <= accNext;
          shReg <= shReg << 4;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            binOut <= accNext;
            err    <= errPend;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboard bench for bcd_to_binary_seq: the driver queues expected results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_bcd_to_binary_seq;

  localparam int DIGITS    = 4;
  localparam int BIN_WIDTH = 14;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [4*DIGITS-1:0]  bcdIn;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [BIN_WIDTH-1:0] binOut;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [BIN_WIDTH-1:0] bin;
    logic                 err;
    int                   acceptCyc;
  } expT;

  expT scb[$];

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_WIDTH(BIN_WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcdIn  (bcdIn),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .binOut (binOut)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (scb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 expected no pending result");
      end else begin
        expT e;
        e = scb.pop_front();
        check("binOut", 32'(binOut), 32'(e.bin));
        check("err", 32'(err), 32'(e.err));
        check("latency", 32'(cyc - e.acceptCyc), 32'(DIGITS));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Called at a negedge with busy low; returns at the negedge after the accept edge.
  task automatic issue(input logic [15:0] bcd, input logic [13:0] expBin, input logic expErr);
    expT e;
    e.bin = expBin;
    e.err = expErr;
    e.acceptCyc = cyc + 1;
    bcdIn = bcd;
    start = 1'b1;
    scb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    bcdIn = 16'hFFFF;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 20);
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
    end
  endtask

  task automatic checkZero(input string name);
    check({name, "_busy"},   32'(busy),   32'd0);
    check({name, "_done"},   32'(done),   32'd0);
    check({name, "_err"},    32'(err),    32'd0);
    check({name, "_binOut"}, 32'(binOut), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    bcdIn = '0;
    repeat (3) @(negedge clk);
    checkZero("reset");
    rst = 1'b1;
    @(negedge clk);

    // reset mid-run, then a clean conversion
    issue(16'h4321, 14'd4321, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    scb.delete();
    #1 checkZero("midreset");
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("midreset_hold_binOut", 32'(binOut), 32'd0);

    issue(16'h1234, 14'd1234, 1'b0);
    waitDone("c1234");
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    issue(16'h9999, 14'd9999, 1'b0);
    waitDone("c9999");
    issue(16'h0000, 14'd0, 1'b0);
    waitDone("c0000");
    @(negedge clk);

    issue(16'h12A4, 14'd1304, 1'b1);
    waitDone("c12A4");
    @(negedge clk);
    issue(16'h0042, 14'd42, 1'b0);
    check("hold_binOut", 32'(binOut), 32'd1304);
    check("hold_err", 32'(err), 32'd1);
    waitDone("c0042");
    @(negedge clk);

    // start while busy is ignored, then back-to-back accept in the done cycle
    issue(16'h0321, 14'd321, 1'b0);
    @(negedge clk);
    start = 1'b1;
    bcdIn = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    waitDone("c0321");
    issue(16'h0007, 14'd7, 1'b0);
    waitDone("c0007");
    @(negedge clk);

    // reset two cycles into 8765, then restart it
    issue(16'h8765, 14'd8765, 1'b0);
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    scb.delete();
    #1 checkZero("reset8765");
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("reset8765_binOut", 32'(binOut), 32'd0);
    issue(16'h8765, 14'd8765, 1'b0);
    waitDone("c8765");

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(scb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
